// File: rtl/alu_mc_pkg.sv
// alu_mc shared definitions: op codes and control state.
// Used by alu_mc and alu_mc_mul.
package alu_mc_pkg;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_XOR  = 3'd3;
  localparam logic [2:0] OP_COM  = 3'd4;
  localparam logic [2:0] OP_MUL  = 3'd5;
  localparam logic [2:0] OP_ADDI = 3'd6;
  localparam logic [2:0] OP_RSVD = 3'd7;

  typedef enum logic {
    IDLE     = 1'b0,
    MUL_BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/alu_mc_mul.sv
// Iterative shift-add multiplier, one partial product per cycle.
// ALU_SIGNED_EN: signed product via magnitude multiply and fix-up.
module alu_mc_mul
  import alu_mc_pkg::*;
#(
  parameter int DSIZE = 16,
  parameter int CNTW  = $clog2(DSIZE + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [DSIZE-1:0]   a,
  input  logic [DSIZE-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*DSIZE-1:0] prod
);

  logic [DSIZE-1:0]   mcand;
  logic [2*DSIZE-1:0] acc;
  logic [CNTW-1:0]    cnt;
  logic               neg;

  logic [DSIZE-1:0]   mag_a;
  logic [DSIZE-1:0]   mag_b;
  logic               neg_in;
  logic [DSIZE:0]     sum;
  logic [2*DSIZE-1:0] nxt;

  // Operand magnitudes and product sign taken at start.
  always_comb begin
`ifdef ALU_SIGNED_EN
    mag_a  = a[DSIZE-1] ? -a : a;
    mag_b  = b[DSIZE-1] ? -b : b;
    neg_in = a[DSIZE-1] ^ b[DSIZE-1];
`else
    mag_a  = a;
    mag_b  = b;
    neg_in = 1'b0;
`endif
  end

  // One shift-add step; final product exposed for the last step.
  always_comb begin
    sum  = {1'b0, acc[2*DSIZE-1:DSIZE]}
         + {1'b0, (acc[0] ? mcand : '0)};
    nxt  = {sum, acc[DSIZE-1:1]};
    prod = neg ? -nxt : nxt;
  end

  assign busy = (cnt != '0);
  assign done = (cnt == CNTW'(1));

  // Accumulator holds {partial high, shifting multiplier}.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand <= '0;
      acc   <= '0;
      cnt   <= '0;
      neg   <= 1'b0;
    end else if (start) begin
      mcand <= mag_a;
      acc   <= {{DSIZE{1'b0}}, mag_b};
      cnt   <= CNTW'(DSIZE);
      neg   <= neg_in;
    end else if (busy) begin
      acc   <= nxt;
      cnt   <= cnt - CNTW'(1);
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready on both sides.
// ALU_SIGNED_EN selects signed COM and MUL.
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int DSIZE = 16,
  parameter int CNTW  = $clog2(DSIZE + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DSIZE-1:0] a,
  input  logic [DSIZE-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DSIZE-1:0] out,
  output logic [DSIZE-1:0] out_hi,
  output logic             zero
);

  state_t             state;
  logic               in_fire;
  logic               out_fire;
  logic               start;
  logic               le;
  logic [DSIZE-1:0]   res;
  logic               mul_busy;
  logic               mul_done;
  logic [2*DSIZE-1:0] prod;

  assign in_ready = (state == IDLE) && !mul_busy
                  && (!out_valid || out_ready);
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign start    = in_fire && (op == OP_MUL);

  // Less-or-equal compare for COM.
  always_comb begin
`ifdef ALU_SIGNED_EN
    le = ($signed(a) <= $signed(b));
`else
    le = (a <= b);
`endif
  end

  // Single-cycle results; MUL handled by the multiplier.
  always_comb begin
    res = '0;
    unique case (op)
      OP_ADD:  res = a + b;
      OP_SUB:  res = a - b;
      OP_AND:  res = a & b;
      OP_XOR:  res = a ^ b;
      OP_COM:  res = {{(DSIZE-1){1'b0}}, le};
      OP_MUL:  res = '0;
      OP_ADDI: res = a + b;
      OP_RSVD: res = '0;
    endcase
  end

  alu_mc_mul #(
    .DSIZE(DSIZE),
    .CNTW (CNTW)
  ) u_mul (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .busy (mul_busy),
    .done (mul_done),
    .prod (prod)
  );

  // Control FSM with registered result, flag and valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out       <= '0;
      out_hi    <= '0;
      zero      <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_fire && op == OP_MUL) begin
            state     <= MUL_BUSY;
            out_valid <= 1'b0;
          end else if (in_fire) begin
            out       <= res;
            out_hi    <= '0;
            zero      <= (res == '0);
            out_valid <= 1'b1;
          end else if (out_fire) begin
            out_valid <= 1'b0;
          end
        end
        MUL_BUSY: begin
          if (out_fire)
            out_valid <= 1'b0;
          if (mul_done) begin
            out       <= prod[DSIZE-1:0];
            out_hi    <= prod[2*DSIZE-1:DSIZE];
            zero      <= (prod[DSIZE-1:0] == '0);
            out_valid <= 1'b1;
            state     <= IDLE;
          end
        end
      endcase
    end
  end

endmodule
